// File: rtl/add_seq.sv
// Multi-cycle wide add/subtract: one SLICE-bit slice per cycle on a shared adder,
// carry rippled through a register, result and flags on a valid/ready handshake.
module add_seq #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovfl,
  output logic             zero
);

  localparam int N     = WIDTH / SLICE;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovfl_q, ovfl_d;
  logic             zero_q, zero_d;

  logic signed [SLICE-1:0] a_sl, b_sl;
  logic [SLICE:0]          sl_sum;

  // Shared slice adder: operands selected by the current slice index
  always_comb begin
    a_sl   = opa_q[int'(idx_q)*SLICE +: SLICE];
    b_sl   = opb_q[int'(idx_q)*SLICE +: SLICE];
    sl_sum = {1'b0, a_sl} + {1'b0, b_sl} + (SLICE+1)'(carry_q);
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovfl_d  = ovfl_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[int'(idx_q)*SLICE +: SLICE] = sl_sum[SLICE-1:0];
        carry_d = sl_sum[SLICE];
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
          idx_d   = '0;
          cout_d  = sl_sum[SLICE];
          ovfl_d  = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                    (sl_sum[SLICE-1] != opa_q[WIDTH-1]);
          // Every slice of sum_d belongs to this operation by now
          zero_d  = (sum_d == '0);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovfl_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovfl_q  <= ovfl_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovfl      = ovfl_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_add_seq.sv
// Scoreboard bench for add_seq: expected results queued at issue, popped by a monitor.
module tb_add_seq;

  localparam int W = 64;
  localparam int S = 16;
  localparam int N = W / S;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         sub = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, cout, ovfl, zero;
  logic [W-1:0] sum;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovfl;
    logic         zero;
  } res_t;

  res_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  bit   rand_rdy = 1'b0;

  add_seq #(.WIDTH(W), .SLICE(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovfl(ovfl), .zero(zero)
  );

  always #5 clk = ~clk;

  // Reference: plain wide arithmetic, signed overflow from a one-bit-wider signed result
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    res_t r;
    logic [W:0] full;
    logic signed [W:0] sx, sy, sr;
    sx = $signed({x[W-1], x});
    sy = $signed({y[W-1], y});
    if (s) begin
      full   = {1'b0, x} - {1'b0, y};
      r.cout = (x >= y);
      sr     = sx - sy;
    end else begin
      full   = {1'b0, x} + {1'b0, y};
      r.cout = full[W];
      sr     = sx + sy;
    end
    r.sum  = full[W-1:0];
    r.ovfl = (sr[W] != sr[W-1]);
    r.zero = (r.sum == '0);
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a transfer is out_valid && out_ready just before the rising edge
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(out_valid), 64'd0);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("sum", sum, e.sum);
        check("flags{cout,ovfl,zero}", 64'({cout, ovfl, zero}), 64'({e.cout, e.ovfl, e.zero}));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                       input bit chk_lat);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 60) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    a = x; b = y; sub = s; in_valid = 1'b1;
    exp_q.push_back(model(x, y, s));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
      if (!out_valid && in_ready) check("busy_in_ready", 64'(in_ready), 64'd0);
    end
    if (chk_lat) check("latency", 64'(lat), 64'(N));
    else if (!out_valid) check("done_timeout", 64'(out_valid), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] snap_sum;
    logic [2:0]   snap_fl;
    res_t         dummy;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", sum, 64'd0);
    check("rst_flags", 64'({cout, ovfl, zero}), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    do_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b1);
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
    do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
    do_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1);
    do_op(64'd5, 64'd7, 1'b1, 1'b1);
    do_op(64'd7, 64'd7, 1'b1, 1'b1);

    // Spot-check the reference against hand-derived values
    dummy = model(64'h0000_0000_0000_FFFF, 64'd1, 1'b0);
    check("ref_slice_carry", dummy.sum, 64'h0000_0000_0001_0000);
    dummy = model(64'd5, 64'd7, 1'b1);
    check("ref_borrow", 64'({dummy.cout, dummy.ovfl, dummy.zero}), 64'd0);

    // Backpressure: result held, in_valid ignored
    @(posedge clk); #1;
    out_ready = 1'b0;
    do_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1);
    snap_sum = sum;
    snap_fl  = {cout, ovfl, zero};
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'(i % 2);
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      @(posedge clk); #1;
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_sum", sum, snap_sum);
      check("bp_flags", 64'({cout, ovfl, zero}), 64'(snap_fl));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("handoff_out_valid", 64'(out_valid), 64'd0);
    check("handoff_in_ready", 64'(in_ready), 64'd1);
    do_op(64'd100, 64'd58, 1'b1, 1'b1);

    // Reset mid-operation: aborted op has no expectation queued
    @(posedge clk); #1;
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_sum", sum, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    do_op(64'd3, 64'd4, 1'b0, 1'b1);

    // Randomized traffic with random output backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] x, y;
      x = {$urandom, $urandom};
      y = (i % 7 == 0) ? x : {$urandom, $urandom};
      if (i % 5 == 0) x[W-1:W-S] = '1;
      do_op(x, y, 1'($urandom), 1'b1);
    end
    rand_rdy = 1'b0;
    #3;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
